// File: rtl/sdrc_bank_arb_if.sv
// Bank-FSM <-> arbiter <-> xfr_ctl command bus.
// slave = arbiter side, master = bank FSMs plus xfr_ctl side.
interface sdrc_bank_arb_if #(
  parameter int REQ_BW = 12,
  parameter int ID_W   = 4
);
  logic [3:0]          b2x_req;
  logic [7:0]          b2x_cmd;
  logic [47:0]         b2x_addr;
  logic [4*REQ_BW-1:0] b2x_len;
  logic [4*ID_W-1:0]   b2x_id;
  logic [3:0]          b2x_start;
  logic [3:0]          b2x_last;
  logic [3:0]          b2x_wrap;
  logic [3:0]          b2x_ack;
  logic [3:0]          trrd_delay;
  logic                x_req;
  logic [1:0]          x_cmd;
  logic [11:0]         x_addr;
  logic [REQ_BW-1:0]   x_len;
  logic [ID_W-1:0]     x_id;
  logic                x_start;
  logic                x_last;
  logic                x_wrap;
  logic [1:0]          x_ba;
  logic                x_ack;

  modport master (
    output b2x_req, b2x_cmd, b2x_addr, b2x_len, b2x_id,
           b2x_start, b2x_last, b2x_wrap, trrd_delay, x_ack,
    input  b2x_ack, x_req, x_cmd, x_addr, x_len, x_id,
           x_start, x_last, x_wrap, x_ba
  );

  modport slave (
    input  b2x_req, b2x_cmd, b2x_addr, b2x_len, b2x_id,
           b2x_start, b2x_last, b2x_wrap, trrd_delay, x_ack,
    output b2x_ack, x_req, x_cmd, x_addr, x_len, x_id,
           x_start, x_last, x_wrap, x_ba
  );
endinterface

// File: rtl/sdrc_bank_arb.sv
// Round-robin arbiter merging four bank FSM command streams into xfr_ctl, with tRRD spacing.
// Optional macro SDR_ARB_XFR_PRIO_EN: eligible RD/WR banks win over PRE/ACT before round robin.
module sdrc_bank_arb #(
  parameter int REQ_BW = 12,
  parameter int ID_W   = 4
) (
  input  logic           clk,
  input  logic           reset,
  sdrc_bank_arb_if.slave bus
);

  // Command encodings match sdrc_define.v
  localparam logic [1:0] OP_ACT = 2'b01;
`ifdef SDR_ARB_XFR_PRIO_EN
  localparam logic [1:0] OP_RD  = 2'b10;
  localparam logic [1:0] OP_WR  = 2'b11;
`endif

  logic [1:0] r_rr_ptr;
  logic [3:0] r_trrd_cnt;
  logic [1:0] w_cmd [4];
  logic [3:0] w_elig;
  logic [3:0] w_cand;
  logic [1:0] w_gnt;
  logic       w_req;
  logic       w_accept;

  // Per-bank command decode; ACTs are held off while the tRRD counter runs
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_cmd[i]  = bus.b2x_cmd[2*i +: 2];
      w_elig[i] = bus.b2x_req[i] & ~((w_cmd[i] == OP_ACT) & (r_trrd_cnt != 4'd0));
    end
  end

`ifdef SDR_ARB_XFR_PRIO_EN
  logic [3:0] w_xfr;

  // Data-transfer tier: RD/WR banks compete alone whenever any is eligible
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_xfr[i] = w_elig[i] & ((w_cmd[i] == OP_RD) | (w_cmd[i] == OP_WR));
    end
    if (|w_xfr) begin
      w_cand = w_xfr;
    end else begin
      w_cand = w_elig;
    end
  end
`else
  assign w_cand = w_elig;
`endif

  // Round-robin search from r_rr_ptr; descending loop lets the nearest candidate win
  always_comb begin
    w_gnt = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (w_cand[r_rr_ptr + 2'(k)]) begin
        w_gnt = r_rr_ptr + 2'(k);
      end else begin
        w_gnt = w_gnt;
      end
    end
  end

  assign w_req    = |w_elig;
  assign w_accept = bus.x_ack & w_req;

  // Forward the granted bank's fields; everything zero when nothing is eligible
  always_comb begin
    if (w_req) begin
      bus.x_cmd   = w_cmd[w_gnt];
      bus.x_addr  = bus.b2x_addr[12*int'(w_gnt) +: 12];
      bus.x_len   = bus.b2x_len[REQ_BW*int'(w_gnt) +: REQ_BW];
      bus.x_id    = bus.b2x_id[ID_W*int'(w_gnt) +: ID_W];
      bus.x_start = bus.b2x_start[w_gnt];
      bus.x_last  = bus.b2x_last[w_gnt];
      bus.x_wrap  = bus.b2x_wrap[w_gnt];
      bus.x_ba    = w_gnt;
    end else begin
      bus.x_cmd   = 2'd0;
      bus.x_addr  = 12'd0;
      bus.x_len   = '0;
      bus.x_id    = '0;
      bus.x_start = 1'b0;
      bus.x_last  = 1'b0;
      bus.x_wrap  = 1'b0;
      bus.x_ba    = 2'd0;
    end
  end

  assign bus.x_req = w_req;

  // Acknowledge only the granted bank, in the same cycle as x_ack
  always_comb begin
    if (w_accept) begin
      bus.b2x_ack = 4'b0001 << w_gnt;
    end else begin
      bus.b2x_ack = 4'b0000;
    end
  end

  // Pointer advances past the served bank; tRRD reloads on an accepted ACT
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr_ptr   <= 2'd0;
      r_trrd_cnt <= 4'd0;
    end else begin
      if (w_accept) begin
        r_rr_ptr <= w_gnt + 2'd1;
      end else begin
        r_rr_ptr <= r_rr_ptr;
      end
      if (w_accept && (w_cmd[w_gnt] == OP_ACT)) begin
        r_trrd_cnt <= bus.trrd_delay;
      end else if (r_trrd_cnt != 4'd0) begin
        r_trrd_cnt <= r_trrd_cnt - 4'd1;
      end else begin
        r_trrd_cnt <= 4'd0;
      end
    end
  end

endmodule

// File: tb/tb_sdrc_bank_arb.sv
// Scoreboard bench for sdrc_bank_arb: a cycle-level reference model pushes expectations,
// a separate monitor compares the DUT outputs every cycle.
module tb_sdrc_bank_arb;

  localparam logic [1:0] OP_PRE = 2'b00;
  localparam logic [1:0] OP_ACT = 2'b01;
  localparam logic [1:0] OP_RD  = 2'b10;
  localparam logic [1:0] OP_WR  = 2'b11;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  sdrc_bank_arb_if #(.REQ_BW(12), .ID_W(4)) bus ();
  sdrc_bank_arb #(.REQ_BW(12), .ID_W(4)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  typedef struct packed {
    logic        req;
    logic [1:0]  cmd;
    logic [11:0] addr;
    logic [11:0] len;
    logic [3:0]  id;
    logic        st;
    logic        la;
    logic        wr;
    logic [1:0]  ba;
  } xout_t;

  typedef struct packed {
    xout_t      x;
    logic [3:0] ack;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state: pointer plus the time and spacing of the last accepted ACT
  int   m_rr = 0;
  int   m_cyc = 0;
  int   m_last_act = 0;
  int   m_last_d = 0;
  bit   m_act_seen = 1'b0;

  function automatic xout_t sample_x();
    xout_t s;
    s.req  = bus.x_req;
    s.cmd  = bus.x_cmd;
    s.addr = bus.x_addr;
    s.len  = bus.x_len;
    s.id   = bus.x_id;
    s.st   = bus.x_start;
    s.la   = bus.x_last;
    s.wr   = bus.x_wrap;
    s.ba   = bus.x_ba;
    return s;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Expected response for the inputs currently on the bus, then advance the model
  task automatic issue();
    exp_t       e;
    int         g;
    bit [3:0]   elig;
    bit [3:0]   cand;
    logic [1:0] c [4];
    e = '0;
    g = -1;
    for (int i = 0; i < 4; i++) begin
      c[i]    = bus.b2x_cmd[2*i +: 2];
      elig[i] = bus.b2x_req[i] &&
                !(c[i] == OP_ACT && m_act_seen && m_cyc <= m_last_act + m_last_d);
    end
    cand = elig;
`ifdef SDR_ARB_XFR_PRIO_EN
    begin
      bit [3:0] xfr;
      for (int i = 0; i < 4; i++) xfr[i] = elig[i] && (c[i] == OP_RD || c[i] == OP_WR);
      if (xfr != 4'd0) cand = xfr;
    end
`endif
    for (int k = 0; k < 4; k++) begin
      if (g < 0 && cand[(m_rr + k) % 4]) g = (m_rr + k) % 4;
    end
    if (g >= 0) begin
      e.x.req  = 1'b1;
      e.x.cmd  = c[g];
      e.x.addr = bus.b2x_addr[12*g +: 12];
      e.x.len  = bus.b2x_len[12*g +: 12];
      e.x.id   = bus.b2x_id[4*g +: 4];
      e.x.st   = bus.b2x_start[g];
      e.x.la   = bus.b2x_last[g];
      e.x.wr   = bus.b2x_wrap[g];
      e.x.ba   = 2'(g);
      if (bus.x_ack) begin
        e.ack = 4'(1 << g);
        m_rr  = (g + 1) % 4;
        if (c[g] == OP_ACT) begin
          m_act_seen = 1'b1;
          m_last_act = m_cyc;
          m_last_d   = int'(bus.trrd_delay);
        end
      end
    end
    m_cyc++;
    sb_q.push_back(e);
  endtask

  task automatic zero_inputs();
    bus.b2x_req    = 4'd0;
    bus.b2x_cmd    = 8'd0;
    bus.b2x_addr   = 48'd0;
    bus.b2x_len    = 48'd0;
    bus.b2x_id     = 16'd0;
    bus.b2x_start  = 4'd0;
    bus.b2x_last   = 4'd0;
    bus.b2x_wrap   = 4'd0;
    bus.trrd_delay = 4'd0;
    bus.x_ack      = 1'b0;
  endtask

  task automatic drive(input logic [3:0] req, input logic [7:0] cmd,
                       input logic ack, input logic [3:0] dly);
    logic [63:0] r64;
    @(negedge clk);
    bus.b2x_req    = req;
    bus.b2x_cmd    = cmd;
    bus.x_ack      = ack;
    bus.trrd_delay = dly;
    r64 = {$urandom, $urandom};
    bus.b2x_addr   = r64[47:0];
    r64 = {$urandom, $urandom};
    bus.b2x_len    = r64[47:0];
    bus.b2x_id     = 16'($urandom);
    bus.b2x_start  = 4'($urandom);
    bus.b2x_last   = 4'($urandom);
    bus.b2x_wrap   = 4'($urandom);
    issue();
  endtask

  // Reset asserted mid-cycle must clear pointer and tRRD counter immediately
  task automatic do_reset();
    @(negedge clk);
    zero_inputs();
    bus.x_ack = 1'b1;
    #3;
    reset = 1'b1;
    #1;
    check("rst_x_req", 32'(bus.x_req), 32'd0);
    check("rst_b2x_ack", 32'(bus.b2x_ack), 32'd0);
    bus.b2x_req = 4'b0011;
    bus.b2x_cmd = {OP_RD, OP_RD, OP_ACT, OP_ACT};
    #1;
    check("rst_act_unmasked", 32'(bus.x_req), 32'd1);
    check("rst_rr_zero", 32'(bus.x_ba), 32'd0);
    zero_inputs();
    @(negedge clk);
    reset = 1'b0;
    m_rr       = 0;
    m_act_seen = 1'b0;
  endtask

  // Monitor: compare DUT outputs against the oldest expectation each cycle
  initial begin
    exp_t  e;
    xout_t s;
    forever begin
      @(negedge clk);
      #2;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        s = sample_x();
        n_tests++;
        if (s !== e.x) begin
          n_fail++;
          $display("FAIL xfr_out cyc=%0d: got req=%0b ba=%0d cmd=%0d addr=%h len=%h id=%h f=%b%b%b expected req=%0b ba=%0d cmd=%0d addr=%h len=%h id=%h f=%b%b%b",
                   m_cyc, s.req, s.ba, s.cmd, s.addr, s.len, s.id, s.st, s.la, s.wr,
                   e.x.req, e.x.ba, e.x.cmd, e.x.addr, e.x.len, e.x.id, e.x.st, e.x.la, e.x.wr);
        end
        n_tests++;
        if (bus.b2x_ack !== e.ack) begin
          n_fail++;
          $display("FAIL b2x_ack: got %b expected %b", bus.b2x_ack, e.ack);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    zero_inputs();
    repeat (2) @(negedge clk);
    check("por_x_req", 32'(bus.x_req), 32'd0);
    check("por_b2x_ack", 32'(bus.b2x_ack), 32'd0);
    reset = 1'b0;

    // Round robin over four RD requesters, then an ack with no request
    repeat (5) drive(4'hF, {OP_RD, OP_RD, OP_RD, OP_RD}, 1'b1, 4'd0);
    drive(4'h0, 8'd0, 1'b1, 4'd0);
    drive(4'hF, {OP_RD, OP_RD, OP_RD, OP_RD}, 1'b1, 4'd0);
    do_reset();

    // tRRD=3: bank0 ACT, bank2 RD slips in, bank1 ACT waits four cycles
    drive(4'b0011, {OP_RD, OP_RD, OP_ACT, OP_ACT}, 1'b1, 4'd3);
    drive(4'b0110, {OP_RD, OP_RD, OP_ACT, OP_ACT}, 1'b1, 4'd3);
    repeat (3) drive(4'b0010, {OP_RD, OP_RD, OP_ACT, OP_ACT}, 1'b1, 4'd3);
    do_reset();

    // Wrap and skip: pointer to 3, then banks 1 and 3 requesting
    drive(4'b0100, {OP_RD, OP_RD, OP_RD, OP_RD}, 1'b1, 4'd0);
    drive(4'b1010, {OP_RD, OP_RD, OP_RD, OP_RD}, 1'b1, 4'd0);
    drive(4'b0010, {OP_RD, OP_RD, OP_RD, OP_RD}, 1'b1, 4'd0);
    do_reset();

    // Bank0 PRE against bank1 WR with pointer at 0
    drive(4'b0011, {OP_RD, OP_RD, OP_WR, OP_PRE}, 1'b0, 4'd0);
    #2;
`ifdef SDR_ARB_XFR_PRIO_EN
    check("prio_grant", 32'(bus.x_ba), 32'd1);
`else
    check("prio_grant", 32'(bus.x_ba), 32'd0);
`endif
    drive(4'b0011, {OP_RD, OP_RD, OP_WR, OP_PRE}, 1'b1, 4'd0);

    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      drive(4'($urandom), 8'($urandom), ($urandom_range(0, 3) != 0),
            4'($urandom_range(0, 6)));
    end

    @(negedge clk);
    zero_inputs();
    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
